// File: rtl/seg_pkg.sv
// seg_pkg: seven-segment digit table shared with the display driver, anode slot
// codes and the frame conversion FSM state type.
package seg_pkg;

   localparam logic [6:0] SEG_D0 = 7'b1000000;
   localparam logic [6:0] SEG_D1 = 7'b1111001;
   localparam logic [6:0] SEG_D2 = 7'b0100100;
   localparam logic [6:0] SEG_D3 = 7'b0110000;
   localparam logic [6:0] SEG_D4 = 7'b0011001;
   localparam logic [6:0] SEG_D5 = 7'b0010010;
   localparam logic [6:0] SEG_D6 = 7'b0000010;
   localparam logic [6:0] SEG_D7 = 7'b1111000;
   localparam logic [6:0] SEG_D8 = 7'b0000000;
   localparam logic [6:0] SEG_D9 = 7'b0010000;

   // Active-low anode codes, one per digit slot.
   localparam logic [3:0] AN_UNITS     = 4'b1110;
   localparam logic [3:0] AN_TENS      = 4'b1101;
   localparam logic [3:0] AN_HUNDREDS  = 4'b1011;
   localparam logic [3:0] AN_THOUSANDS = 4'b0111;
   localparam logic [3:0] AN_BLANK     = 4'b1111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } conv_state_t;

endpackage

// File: rtl/seg_pattern_decode.sv
// seg_pattern_decode: maps an active-low segment pattern onto its decimal digit
// and flags patterns that are not in the shared digit table.
module seg_pattern_decode
   import seg_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] digit,
   output logic       legal
);

   // Table lookup; anything outside the table is reported as illegal.
   always_comb begin
      digit = 4'd0;
      legal = 1'b1;
      case (seg)
         SEG_D0:  digit = 4'd0;
         SEG_D1:  digit = 4'd1;
         SEG_D2:  digit = 4'd2;
         SEG_D3:  digit = 4'd3;
         SEG_D4:  digit = 4'd4;
         SEG_D5:  digit = 4'd5;
         SEG_D6:  digit = 4'd6;
         SEG_D7:  digit = 4'd7;
         SEG_D8:  digit = 4'd8;
         SEG_D9:  digit = 4'd9;
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: recovers a 4-digit frame from a multiplexed 7-segment scan.
// Define SEG_BIN_CONV_EN to add the serial BCD-to-binary CONV stage and value output.
module seg_scan_decoder
   import seg_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 32'd16
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  seg_in,
   input  logic [3:0]  an_in,
   output logic [15:0] bcd,
   output logic [13:0] value,
   output logic        frame_valid,
   output logic        seg_err,
   output logic        an_err,
   output logic        busy
);

   localparam logic [15:0] CNT_TARGET = 16'(STABLE_CYCLES);

   logic [10:0]  samp_r;
   logic [15:0]  cnt_r;
   logic         same_s;
   logic         eval_s;
   logic [3:0]   dec_digit_s;
   logic         dec_legal_s;
   logic [1:0]   slot_s;
   logic         one_low_s;
   logic         multi_low_s;
   logic         cap_s;
   logic         start_s;
   conv_state_t  state_r;
   conv_state_t  state_nx_s;
   logic [3:0]   seen_r;
   logic [3:0]   seen_nx_s;
   logic [15:0]  shadow_r;
   logic [15:0]  shadow_nx_s;
   logic [15:0]  conv_bcd_r;
`ifdef SEG_BIN_CONV_EN
   logic [1:0]   step_r;
   logic [13:0]  acc_r;
   logic [3:0]   conv_digit_s;
`endif

   // Evaluation fires only on the edge where the count first reaches the target.
   assign same_s  = ({an_in, seg_in} == samp_r);
   assign eval_s  = same_s && (cnt_r == (CNT_TARGET - 16'd1));
   assign cap_s   = eval_s && one_low_s && dec_legal_s;
   assign start_s = (state_r == IDLE) && (seen_r == 4'b1111);

   // Input sample register and saturating run-length counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         samp_r <= 11'd0;
         cnt_r  <= 16'd0;
      end else begin
         samp_r <= {an_in, seg_in};
         if (!same_s) begin
            cnt_r <= 16'd1;
         end else if (cnt_r != CNT_TARGET) begin
            cnt_r <= cnt_r + 16'd1;
         end else begin
            cnt_r <= cnt_r;
         end
      end
   end

   seg_pattern_decode u_decode (
      .seg   (samp_r[6:0]),
      .digit (dec_digit_s),
      .legal (dec_legal_s)
   );

   // Anode classification: single slot, blank, or several anodes driven at once.
   always_comb begin
      slot_s      = 2'd0;
      one_low_s   = 1'b1;
      multi_low_s = 1'b0;
      case (samp_r[10:7])
         AN_UNITS:     slot_s = 2'd0;
         AN_TENS:      slot_s = 2'd1;
         AN_HUNDREDS:  slot_s = 2'd2;
         AN_THOUSANDS: slot_s = 2'd3;
         AN_BLANK:     one_low_s = 1'b0;
         default: begin
            one_low_s   = 1'b0;
            multi_low_s = 1'b1;
         end
      endcase
   end

   // Capture wins over the start-of-conversion clear so that digit is kept.
   always_comb begin
      seen_nx_s   = start_s ? 4'b0000 : seen_r;
      shadow_nx_s = shadow_r;
      if (cap_s) begin
         seen_nx_s[slot_s]                     = 1'b1;
         shadow_nx_s[{slot_s, 2'b00} +: 4]     = dec_digit_s;
      end else begin
         shadow_nx_s = shadow_r;
      end
   end

   // Conversion FSM next-state logic.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE: begin
            if (seen_r == 4'b1111) begin
`ifdef SEG_BIN_CONV_EN
               state_nx_s = CONV;
`else
               state_nx_s = DONE;
`endif
            end else begin
               state_nx_s = IDLE;
            end
         end
         CONV: begin
`ifdef SEG_BIN_CONV_EN
            if (step_r == 2'd3) begin
               state_nx_s = DONE;
            end else begin
               state_nx_s = CONV;
            end
`else
            state_nx_s = IDLE;
`endif
         end
         DONE:    state_nx_s = IDLE;
         default: state_nx_s = IDLE;
      endcase
   end

   // FSM state, digit shadow and registered frame/error outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         seen_r      <= 4'd0;
         shadow_r    <= 16'd0;
         conv_bcd_r  <= 16'd0;
         bcd         <= 16'd0;
         frame_valid <= 1'b0;
         seg_err     <= 1'b0;
         an_err      <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state_r     <= state_nx_s;
         seen_r      <= seen_nx_s;
         shadow_r    <= shadow_nx_s;
         seg_err     <= eval_s && one_low_s && !dec_legal_s;
         an_err      <= eval_s && multi_low_s;
         busy        <= (state_nx_s != IDLE);
         frame_valid <= (state_r == DONE);
         conv_bcd_r  <= start_s ? shadow_r : conv_bcd_r;
         bcd         <= (state_r == DONE) ? conv_bcd_r : bcd;
      end
   end

`ifdef SEG_BIN_CONV_EN
   // Step 0 selects the thousands digit, step 3 the units digit.
   assign conv_digit_s = conv_bcd_r[{~step_r, 2'b00} +: 4];

   // Horner accumulation of the snapshot and the registered binary value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         step_r <= 2'd0;
         acc_r  <= 14'd0;
         value  <= 14'd0;
      end else begin
         if (start_s) begin
            step_r <= 2'd0;
            acc_r  <= 14'd0;
         end else if (state_r == CONV) begin
            step_r <= step_r + 2'd1;
            acc_r  <= (acc_r * 14'd10) + {10'd0, conv_digit_s};
         end else begin
            step_r <= step_r;
            acc_r  <= acc_r;
         end
         value <= (state_r == DONE) ? acc_r : value;
      end
   end
`else
   assign value = 14'd0;
`endif

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 16: identical consecutive samples required before a digit is accepted (legal range 2..65535).
REQ-002 SHALL have port clk, input, 1: clock; all other inputs are synchronous to clk.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port seg_in, input, 7: active-low segment lines, bit 6 = g ... bit 0 = a.
REQ-005 SHALL have port an_in, input, 4: active-low anodes, bit 0 = units ... bit 3 = thousands.
REQ-006 SHALL have port bcd, output, 16: last complete frame as BCD, with thousands in bits [15:12].
REQ-007 SHALL have port value, output, 14: last complete frame in binary, 0..9999.
REQ-008 SHALL have port frame_valid, output, 1: one-cycle pulse when bcd and value are updated.
REQ-009 SHALL have port seg_err, output, 1: one-cycle pulse when a stable segment pattern is not a legal digit.
REQ-010 SHALL have port an_err, output, 1: one-cycle pulse when a stable anode value has more than one bit low.
REQ-011 SHALL have port busy, output, 1: high while the conversion FSM is not IDLE.

Function
REQ-012 SHALL register {an_in, seg_in} each cycle and count consecutive identical samples; the count restarts at 1 on any change and saturates.
REQ-013 SHALL evaluate a dwell exactly once, in the cycle the count reaches STABLE_CYCLES; the next evaluation requires an input change followed by a new stable period.
REQ-014 SHALL treat an_in = 4'b1111 at evaluation as blank: no capture, no error.
REQ-015 SHALL, at evaluation with exactly one an_in bit low and a legal pattern, write the decoded digit to shadow[slot] and set seen[slot]; a repeated slot overwrites.
REQ-016 SHALL, at evaluation with more than one an_in bit low, pulse an_err and leave shadow and seen unchanged.
REQ-017 SHALL, at evaluation with one an_in bit low and an illegal pattern (including all-ones), pulse seg_err and leave the slot unchanged.
REQ-018 SHALL use FSM states IDLE, CONV, DONE: IDLE->CONV when seen==4'b1111; on that transition, snapshot shadow into conv_bcd and clear seen.
REQ-019 SHALL, in CONV, run 4 steps, thousands digit first: acc <= acc*10 + digit; after step 4 go to DONE.
REQ-020 SHALL, in DONE, load bcd<=conv_bcd and value<=acc, pulse frame_valid, and return to IDLE; latency from seen becoming full to frame_valid is 6 cycles.
REQ-021 SHALL keep capturing into shadow/seen while CONV/DONE; if seen fills again while busy, it is held and conversion starts on return to IDLE, with no frames dropped or merged.
REQ-022 SHALL keep bcd and value stable between frame_valid pulses.
REQ-023 SHALL give a capture in the same cycle as the IDLE->CONV clear priority, so that digit survives in seen.

Reset
REQ-024 SHALL, on rst, clear bcd, value, frame_valid, seg_err, an_err, busy, seen, shadow, acc, the sample register and the count, and set FSM=IDLE; no frame_valid follows a reset taken mid-CONV.

Configuration
REQ-025 SHALL, with SEG_BIN_CONV_EN defined, implement CONV and the value output exactly as above.
REQ-026 SHALL, without SEG_BIN_CONV_EN, omit CONV: IDLE->DONE directly, frame_valid 2 cycles after seen is full, value tied to 0, busy high only in DONE.

Structure
REQ-027 SHALL place the legal digit patterns in shared package seg_pkg, together with the anode slot constants and the FSM state type; the display driver uses the same table: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-028 SHALL implement pattern lookup in combinational sub-module seg_pattern_decode, with outputs digit[3:0] and legal.

Verification
REQ-029 SHALL cover: scan 1,2,3,4 (units first), each held 32 cycles, STABLE_CYCLES=16 -> one frame_valid, bcd=16'h4321, value=4321.
REQ-030 SHALL cover: units pattern held only 10 cycles within an otherwise valid scan -> no frame_valid until a 16-cycle dwell on units occurs.
REQ-031 SHALL cover: an_in=4'b1100 held 20 cycles -> single an_err pulse, seen unchanged.
REQ-032 SHALL cover: seg_in=7'b1111111 on tens slot -> seg_err pulse, then tens=7 -> frame with bcd[7:4]=7.
REQ-033 SHALL cover: rst asserted 2 cycles into CONV -> no frame_valid, all outputs 0; and, without SEG_BIN_CONV_EN, scan 9,9,9,9 -> bcd=16'h9999, value=0.
